// File: rtl/decode_pkg.sv
// Shared definitions for the 16-bit core decode stage: instruction field
// positions, register address width and immediate-size encoding.
package decode_pkg;

    localparam int unsigned REG_AW  = 4;
    localparam int unsigned INSTR_W = 16;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 8;
    localparam int unsigned RS_HI  = 7;
    localparam int unsigned RS_LO  = 4;
    localparam int unsigned RT_HI  = 3;
    localparam int unsigned RT_LO  = 0;

    localparam int unsigned IMM4_HI = 3;
    localparam int unsigned IMM8_HI = 7;
    localparam int unsigned IMM9_HI = 8;

    typedef enum logic [1:0] {
        IMM4_S = 2'b00,
        IMM8_S = 2'b01,
        IMM9_S = 2'b10,
        IMM8_Z = 2'b11
    } imm_size_e;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports that see a
// same-cycle write through the bypass, one synchronous write port.
module reg_file
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREGS   = 16,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_c_o,
    output logic [DATA_W-1:0] rdata2_c_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] a);
        if (ZERO_R0 && a == '0) return '0;
        if (we_i && waddr_i == a) return wdata_i;
        if (32'(a) < NREGS) return regs_q[a[IDX_W-1:0]];
        return '0;
    endfunction

    assign rdata1_c_o = read_port(raddr1_i);
    assign rdata2_c_o = read_port(raddr2_i);

    // Out-of-range addresses and R0 (when hardwired) never take a write.
    always_comb begin
        regs_d = regs_q;
        if (we_i && (32'(waddr_i) < NREGS) && !(ZERO_R0 && waddr_i == '0)) begin
            regs_d[waddr_i[IDX_W-1:0]] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// Pipelined decode stage: field/immediate extraction, register read with
// writeback bypass, pending-write scoreboard and a valid/ready ID/EX register.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREGS   = 16,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         imm_size,
    input  logic               src2_is_rd,
    input  logic               uses_src1,
    input  logic               uses_src2,
    input  logic               reg_write,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_reg_write,
    output logic [DATA_W-1:0]  out_imm,
    output logic [DATA_W-1:0]  out_data1,
    output logic [DATA_W-1:0]  out_data2
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [3:0]        opc_c;
    logic [REG_AW-1:0] rd_c, rs_c, rt_c, addr2_c;
    logic [DATA_W-1:0] rdata1_c, rdata2_c, imm_c;
    logic              hazard_c, accept_c;

    logic [NREGS-1:0]  busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [3:0]        opc_q, opc_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] imm_q, imm_d, d1_q, d1_d, d2_q, d2_d;

    assign opc_c   = instr[OPC_HI:OPC_LO];
    assign rd_c    = instr[RD_HI:RD_LO];
    assign rs_c    = instr[RS_HI:RS_LO];
    assign rt_c    = instr[RT_HI:RT_LO];
    assign addr2_c = src2_is_rd ? rd_c : rt_c;

    reg_file #(.DATA_W(DATA_W), .NREGS(NREGS), .ZERO_R0(ZERO_R0)) u_rf (
        .clk        (clk),
        .rst        (rst),
        .raddr1_i   (rs_c),
        .raddr2_i   (addr2_c),
        .rdata1_c_o (rdata1_c),
        .rdata2_c_o (rdata2_c),
        .we_i       (wb_en),
        .waddr_i    (wb_addr),
        .wdata_i    (wb_data)
    );

    function automatic logic in_range(input logic [REG_AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    // A register still waits on its producer unless it writes back this cycle.
    function automatic logic pending(input logic [REG_AW-1:0] a);
        return in_range(a) && busy_q[a[IDX_W-1:0]] && !(wb_en && wb_addr == a);
    endfunction

    assign hazard_c = in_valid && ((uses_src1 && pending(rs_c)) ||
                                   (uses_src2 && pending(addr2_c)) ||
                                   (reg_write && pending(rd_c)));
    assign in_ready = rst && (!valid_q || out_ready) && !hazard_c && !flush;
    assign accept_c = in_valid && in_ready;

    always_comb begin
        imm_c = '0;
        case (imm_size_e'(imm_size))
            IMM4_S:  imm_c = DATA_W'($signed(instr[IMM4_HI:0]));
            IMM8_S:  imm_c = DATA_W'($signed(instr[IMM8_HI:0]));
            IMM9_S:  imm_c = DATA_W'($signed(instr[IMM9_HI:0]));
            IMM8_Z:  imm_c = DATA_W'(instr[IMM8_HI:0]);
            default: imm_c = '0;
        endcase
    end

    // Clears are applied before the set so a same-cycle set wins.
    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        imm_d   = imm_q;
        d1_d    = d1_q;
        d2_d    = d2_q;

        if (wb_en && in_range(wb_addr)) busy_d[wb_addr[IDX_W-1:0]] = 1'b0;
        if (flush && valid_q && rw_q && in_range(rd_q)) busy_d[rd_q[IDX_W-1:0]] = 1'b0;
        if (accept_c && reg_write && in_range(rd_c) && !(ZERO_R0 && rd_c == '0)) begin
            busy_d[rd_c[IDX_W-1:0]] = 1'b1;
        end

        if (accept_c) begin
            valid_d = 1'b1;
            opc_d   = opc_c;
            rd_d    = rd_c;
            rw_d    = reg_write;
            imm_d   = imm_c;
            d1_d    = rdata1_c;
            d2_d    = rdata2_c;
        end else if (flush || out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            opc_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            imm_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            imm_q   <= imm_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_opcode    = opc_q;
    assign out_rd        = rd_q;
    assign out_reg_write = rw_q;
    assign out_imm       = imm_q;
    assign out_data1     = d1_q;
    assign out_data2     = d2_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: immediate table, directed hazard/stall/flush
// sequences, then random traffic against an instruction-level model.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] instr;
    logic [1:0]  imm_size;
    logic        src2_is_rd, uses_src1, uses_src2, reg_write, flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_opcode, out_rd;
    logic        out_reg_write;
    logic [15:0] out_imm, out_data1, out_data2;

    always #5 clk = ~clk;

    decode_stage_p #(.DATA_W(16), .NREGS(16), .ZERO_R0(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .imm_size      (imm_size),
        .src2_is_rd    (src2_is_rd),
        .uses_src1     (uses_src1),
        .uses_src2     (uses_src2),
        .reg_write     (reg_write),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_imm       (out_imm),
        .out_data1     (out_data1),
        .out_data2     (out_data2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 0; instr = '0; imm_size = '0; src2_is_rd = 0;
        uses_src1 = 0; uses_src2 = 0; reg_write = 0; flush = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [1:0]  isz;
        logic [15:0] imm;
        logic [3:0]  opc;
        logic [3:0]  rd;
    } vec_t;
    vec_t vt[8];

    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic        rw;
        logic [15:0] imm;
        logic [15:0] d1;
        logic [15:0] d2;
    } mout_t;

    logic [15:0] m_regs [16];
    bit          m_busy [16];
    bit          m_ov;
    mout_t       mo, nxt;

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (a == 0) return 16'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_wait(input logic [3:0] a);
        return m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    // Immediate from the field's numeric value, reinterpreted as signed when needed.
    function automatic logic [15:0] m_imm(input logic [15:0] ins, input logic [1:0] isz);
        int v;
        case (isz)
            2'b00: begin v = int'(ins[3:0]); if (v >= 8)   v -= 16;  end
            2'b01: begin v = int'(ins[7:0]); if (v >= 128) v -= 256; end
            2'b10: begin v = int'(ins[8:0]); if (v >= 256) v -= 512; end
            default: v = int'(ins[7:0]);
        endcase
        return 16'(v);
    endfunction

    int      cand[$];
    bit      hz, exp_rdy, acc;
    logic [3:0] r_rd, r_rs, r_rt, r_a2;

    initial begin
        vt[0] = '{16'h12F8, 2'b01, 16'hFFF8, 4'h1, 4'h2};
        vt[1] = '{16'h12F8, 2'b11, 16'h00F8, 4'h1, 4'h2};
        vt[2] = '{16'h12F8, 2'b00, 16'hFFF8, 4'h1, 4'h2};
        vt[3] = '{16'h12F8, 2'b10, 16'h00F8, 4'h1, 4'h2};
        vt[4] = '{16'h13F8, 2'b10, 16'hFFF8, 4'h1, 4'h3};
        vt[5] = '{16'hA907, 2'b00, 16'h0007, 4'hA, 4'h9};
        vt[6] = '{16'hC47F, 2'b01, 16'h007F, 4'hC, 4'h4};
        vt[7] = '{16'h5E80, 2'b11, 16'h0080, 4'h5, 4'hE};

        // Reset: in_ready low during the reset cycle, every output cleared
        idle(); rst = 0;
        @(posedge clk); #1;
        in_valid = 1; instr = 16'h12F8; #1;
        chk("rst_in_ready", in_ready, 0);
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_opcode", out_opcode, 0);
        chk("rst_out_data1", out_data1, 0);
        rst = 1; idle();

        // Immediate table, accepted back to back
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; instr = vt[i].ins; imm_size = vt[i].isz;
            tick();
            chk($sformatf("imm%0d_valid", i), out_valid, 1);
            chk($sformatf("imm%0d_imm", i), out_imm, vt[i].imm);
            chk($sformatf("imm%0d_opc", i), out_opcode, vt[i].opc);
            chk($sformatf("imm%0d_rd", i), out_rd, vt[i].rd);
        end

        // Writeback then read, plus same-cycle bypass on port 2
        idle(); wb_en = 1; wb_addr = 3; wb_data = 16'hABCD; tick();
        idle(); in_valid = 1; instr = 16'h0034; uses_src1 = 1; uses_src2 = 1;
        wb_en = 1; wb_addr = 4; wb_data = 16'h1234; tick();
        chk("byp_data1", out_data1, 16'hABCD);
        chk("byp_data2", out_data2, 16'h1234);
        idle(); in_valid = 1; instr = 16'h0300; src2_is_rd = 1; tick();
        chk("src2rd_data2", out_data2, 16'hABCD);
        chk("src2rd_data1_r0", out_data1, 16'h0);

        // RAW hazard on R5, released the cycle R5 writes back
        idle(); in_valid = 1; instr = 16'h2500; reg_write = 1; tick();
        chk("haz_prod_rd", out_rd, 5);
        idle(); in_valid = 1; instr = 16'h3050; uses_src1 = 1; #1;
        chk("haz_stall0", in_ready, 0); tick(); #1;
        chk("haz_stall1", in_ready, 0); tick();
        chk("haz_drained", out_valid, 0);
        wb_en = 1; wb_addr = 5; wb_data = 16'h5555; #1;
        chk("haz_release", in_ready, 1); tick();
        chk("haz_valid", out_valid, 1);
        chk("haz_data1", out_data1, 16'h5555);
        chk("haz_opc", out_opcode, 3);

        // Downstream backpressure for 3 cycles
        idle(); tick();
        chk("bp_empty", out_valid, 0);
        in_valid = 1; instr = 16'h4123; out_ready = 0; tick();
        chk("bp_first", out_opcode, 4);
        instr = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            #1; chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
            tick();
            chk($sformatf("bp%0d_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_opc", i), out_opcode, 4);
            chk($sformatf("bp%0d_rd", i), out_rd, 1);
        end
        out_ready = 1; #1;
        chk("bp_release", in_ready, 1); tick();
        chk("bp_second_opc", out_opcode, 5);
        chk("bp_second_rd", out_rd, 6);
        in_valid = 0; tick();
        chk("bp_no_dup", out_valid, 0);

        // Flush a held write to R7; its reader must not stall afterwards
        idle(); out_ready = 0; in_valid = 1; instr = 16'h6700; reg_write = 1; tick();
        chk("fl_held_rd", out_rd, 7);
        chk("fl_held_rw", out_reg_write, 1);
        idle(); out_ready = 0; flush = 1; in_valid = 1; instr = 16'h7070; uses_src1 = 1; #1;
        chk("fl_no_accept", in_ready, 0); tick();
        chk("fl_killed", out_valid, 0);
        flush = 0; out_ready = 1; #1;
        chk("fl_reader_ready", in_ready, 1); tick();
        chk("fl_reader_valid", out_valid, 1);
        chk("fl_reader_opc", out_opcode, 7);

        // R0 hardwired to zero and never busy
        idle(); wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF; tick();
        idle(); in_valid = 1; instr = 16'h8000; uses_src1 = 1; uses_src2 = 1; reg_write = 1;
        wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF; tick();
        chk("r0_data1", out_data1, 0);
        chk("r0_data2", out_data2, 0);
        idle(); in_valid = 1; instr = 16'h9000; uses_src1 = 1; reg_write = 1; #1;
        chk("r0_no_stall", in_ready, 1); tick();
        chk("r0_opc", out_opcode, 9);

        // Reset while stalled discards the pending write to R9
        idle(); in_valid = 1; instr = 16'h2900; reg_write = 1; tick();
        idle(); in_valid = 1; instr = 16'h3090; uses_src1 = 1; #1;
        chk("rs_stall", in_ready, 0);
        rst = 0; tick(); rst = 1;
        chk("rs_valid_cleared", out_valid, 0);
        #1; chk("rs_busy_gone", in_ready, 1); tick();
        chk("rs_reader_opc", out_opcode, 3);
        chk("rs_reader_data", out_data1, 0);
        idle(); wb_en = 1; wb_addr = 9; wb_data = 16'h0909; tick();
        idle(); in_valid = 1; instr = 16'h3090; uses_src1 = 1; tick();
        chk("rs_late_wb", out_data1, 16'h0909);

        // Random traffic against the model, from a fresh reset
        idle(); rst = 0; tick(); rst = 1;
        for (int r = 0; r < 16; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
        m_ov = 0;
        mo = '{4'h0, 4'h0, 1'b0, 16'h0, 16'h0, 16'h0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rd = 4'($urandom_range(0, 5));
            r_rs = 4'($urandom_range(0, 5));
            r_rt = 4'($urandom_range(0, 5));
            instr = {4'($urandom), r_rd, r_rs, r_rt};
            in_valid   = ($urandom % 4) != 0;
            imm_size   = 2'($urandom);
            src2_is_rd = 1'($urandom);
            uses_src1  = 1'($urandom);
            uses_src2  = 1'($urandom);
            reg_write  = 1'($urandom);
            out_ready  = ($urandom % 4) != 0;
            flush      = ($urandom % 16) == 0;
            cand.delete();
            for (int r = 0; r < 16; r++) if (m_busy[r]) cand.push_back(r);
            wb_en   = ($urandom % 3) == 0;
            wb_addr = (cand.size() > 0 && ($urandom % 4) != 0) ?
                      4'(cand[$urandom % cand.size()]) : 4'($urandom);
            wb_data = 16'($urandom);
            #1;
            r_a2 = src2_is_rd ? r_rd : r_rt;
            hz = in_valid && ((uses_src1 && m_wait(r_rs)) || (uses_src2 && m_wait(r_a2)) ||
                              (reg_write && m_wait(r_rd)));
            exp_rdy = (!m_ov || out_ready) && !hz && !flush;
            chk("rnd_in_ready", in_ready, exp_rdy);
            acc = in_valid && exp_rdy;
            nxt = '{instr[15:12], r_rd, reg_write, m_imm(instr, imm_size), m_read(r_rs), m_read(r_a2)};
            @(posedge clk);
            if (wb_en) m_busy[wb_addr] = 0;
            if (flush && m_ov && mo.rw) m_busy[mo.rd] = 0;
            if (acc && reg_write && r_rd != 0) m_busy[r_rd] = 1;
            if (acc) begin m_ov = 1; mo = nxt; end
            else if (flush || out_ready) m_ov = 0;
            if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
            #1;
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("rnd_opc", out_opcode, mo.opc);
                chk("rnd_rd", out_rd, mo.rd);
                chk("rnd_rw", out_reg_write, mo.rw);
                chk("rnd_imm", out_imm, mo.imm);
                chk("rnd_data1", out_data1, mo.d1);
                chk("rnd_data2", out_data2, mo.d2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised, pipelined instruction-decode stage for the 16-bit core: extracts fields and immediates, reads an internal register file with writeback bypass, tracks pending writes in a scoreboard, and registers the result into a valid/ready ID/EX pipeline register. Sits between fetch (upstream handshake) and execute (downstream handshake). Receives writeback from the WB stage.

## Interface
Parameters:
- DATA_W, 16, register/immediate datapath width (≥16)
- NREGS, 16, architectural registers (power of 2, ≤16; addresses come from 4-bit fields)
- ZERO_R0, 1, when 1 R0 reads 0, ignores writes, and is never marked busy

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid / in_ready  in/out  1  fetch→decode handshake
- instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
- imm_size  in  2  00 sext imm[3:0], 01 sext imm[7:0], 10 sext imm[8:0], 11 zext imm[7:0]
- src2_is_rd  in  1  port-2 address = rd (store-type), else rt
- uses_src1, uses_src2  in  1  operand actually consumed (hazard check only when set)
- reg_write  in  1  instruction writes rd
- flush  in  1  kill instruction held in output register
- wb_en, wb_addr[3:0], wb_data[DATA_W]  in  writeback port
- out_valid / out_ready  out/in  1  decode→execute handshake
- out_opcode[4], out_rd[4], out_reg_write[1], out_imm[DATA_W], out_data1[DATA_W], out_data2[DATA_W]  out  registered decode result

## Operation
- Immediate: selected field, sign- or zero-extended to DATA_W per imm_size.
- Register read: combinational, addr1 = rs, addr2 = src2_is_rd ? rd : rt. Bypass: wb_en && wb_addr == addr returns wb_data same cycle. R0 = 0 when ZERO_R0.
- Scoreboard: busy[NREGS]. Set busy[rd] on accept with reg_write (rd≠0 if ZERO_R0). Clear busy[wb_addr] on wb_en. Same register set and cleared in one cycle → set wins.
- Hazard = in_valid && ((uses_src1 && busy[rs] && !(wb_en && wb_addr==rs)) || (uses_src2 && same for addr2) || (reg_write && busy[rd] && !(wb_en && wb_addr==rd))). WAW stalls, so at most one pending write per register.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready): output register loads all fields, out_valid←1.
- out_valid && out_ready with no accept: out_valid←0; data fields hold.
- flush: out_valid←0; if held instruction had out_reg_write, clear busy[out_rd] (unless wb_en also clears it — same result). No accept in flush cycle.
- Writes with wb_addr ≥ NREGS ignored.

## Timing
- Reset (rst low at edge): all registers, busy bits, out_valid, and every out_* cleared to 0; in_ready reads 0 during reset cycle.
- Decode latency 1 cycle: accept at edge N → out_valid high after N.
- Full throughput: back-to-back accept with out_ready held high and no hazards.
- Write port: wb_data written at edge; same-cycle read sees it via bypass; a hazard clears the cycle its producer writes back (stall released combinationally).
- out_* stable while out_valid && !out_ready.
- Reset mid-stall: pending busy bits discarded; later writeback to that register simply writes.

## Structure
- Package decode_pkg: imm_size enum (IMM4_S, IMM8_S, IMM9_S, IMM8_Z), instruction field bit positions, REG_AW = 4.
- Sub-module reg_file: NREGS×DATA_W, two combinational read ports with write bypass, one sync write port, ZERO_R0 handling.
- Scoreboard, immediate extractor, and pipeline register stay in decode_stage_p.

## Test plan
- Reset then imm_size sweep: instr 16'h1_2_F8 → out_imm: 01 → 16'hFFF8, 11 → 16'h00F8, 00 → 16'hFFF8, 10 with instr[8]=0 → 16'h00F8.
- wb R3=16'hABCD; next cycle decode rs=3 → out_data1=16'hABCD; same-cycle wb R4=16'h1234 with rt=4 → out_data2=16'h1234 (bypass).
- Issue write to R5; next instr reads R5 → in_ready=0 until wb_en to R5, accepted that same cycle with wb_data on out_data1.
- out_ready low 3 cycles with in_valid high → out_* unchanged, in_ready=0, no instruction lost or duplicated.
- Accept write to R7, assert flush before out_ready → out_valid=0, busy[R7]=0, next reader of R7 accepted without stall.
- ZERO_R0=1: wb R0=16'hFFFF, then read R0 → 0; reg_write to R0 creates no stall.
